// File: rtl/regfile_sweep_pkg.sv
// regfile_sweep_pkg: shared register-file constants and sweep FSM encoding
package regfile_sweep_pkg;
  localparam int REG_LENGTH = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int REG_NUM = 32;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  typedef enum logic {RF_CLEAR = 1'b0, RF_RUN = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_sweep_rf_read_port.sv
// rf_read_port: combinational read mux with enable/$0/ready gating and write bypass
module rf_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ready_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] mem_i [NUM_REGS],
  output logic [DATA_W-1:0] data_o
);
  assign data_o = (!rd_i || addr_i == '0 || !ready_i) ? '0 :
                  (wr_i && wr_addr_i == addr_i) ? wr_data_i : mem_i[addr_i];
endmodule

// File: rtl/regfile_sweep.sv
// regfile_sweep: 32x32 register file, cleared by a one-register-per-cycle sweep after reset
module regfile_sweep
  import regfile_sweep_pkg::*;
#(
  parameter int DATA_W = REG_LENGTH,
  parameter int ADDR_W = REG_ADDR_LEN,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regaRd,
  input  logic [ADDR_W-1:0] regaAddr,
  output logic [DATA_W-1:0] regaData,
  input  logic              regbRd,
  input  logic [ADDR_W-1:0] regbAddr,
  output logic [DATA_W-1:0] regbData,
  input  logic              regcWr,
  input  logic [ADDR_W-1:0] regcAddr,
  input  logic [DATA_W-1:0] regcData,
  output logic              ready,
  output logic              wr_err
);
  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  assign ready = state_q == RF_RUN;
  assign wr_err = wr_err_q;
  always_comb begin
    state_d = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_err_d = wr_err_q;
    if (state_q == RF_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      state_d = (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) ? RF_RUN : RF_CLEAR;
    end
    if (regcWr == ENABLE && !ready) wr_err_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RF_CLEAR;
      clr_cnt_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_err_q <= wr_err_d;
    end
  end
  // No reset on the array: contents are defined solely by the sweep.
  always_ff @(posedge clk) begin
    if (rst && state_q == RF_CLEAR) mem_q[clr_cnt_q] <= '0;
    else if (rst && ready && regcWr && regcAddr != '0) mem_q[regcAddr] <= regcData;
  end
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd_a (
    .rd_i(regaRd), .addr_i(regaAddr), .ready_i(ready), .wr_i(regcWr),
    .wr_addr_i(regcAddr), .wr_data_i(regcData), .mem_i(mem_q), .data_o(regaData)
  );
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd_b (
    .rd_i(regbRd), .addr_i(regbAddr), .ready_i(ready), .wr_i(regcWr),
    .wr_addr_i(regcAddr), .wr_data_i(regcData), .mem_i(mem_q), .data_o(regbData)
  );
endmodule

// File: tb/tb_regfile_sweep.sv
// tb_regfile_sweep: table-driven scoreboard bench for regfile_sweep
module tb_regfile_sweep;
  logic        clk = 1'b0;
  logic        rst, regaRd, regbRd, regcWr, ready, wr_err;
  logic [4:0]  regaAddr, regbAddr, regcAddr;
  logic [31:0] regaData, regbData, regcData;
  typedef struct {
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ard;
    logic [4:0]  aaddr;
    logic        brd;
    logic [4:0]  baddr;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  vec_t tbl [12];
  exp_t sb [$];
  exp_t e;
  int vec_n = 0;
  int err_n = 0;
  always #5 clk = ~clk;
  regfile_sweep dut (
    .clk(clk), .rst(rst),
    .regaRd(regaRd), .regaAddr(regaAddr), .regaData(regaData),
    .regbRd(regbRd), .regbAddr(regbAddr), .regbData(regbData),
    .regcWr(regcWr), .regcAddr(regcAddr), .regcData(regcData),
    .ready(ready), .wr_err(wr_err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ard, input logic [4:0] aa, input logic brd, input logic [4:0] ba);
    regcWr = wr; regcAddr = wa; regcData = wd;
    regaRd = ard; regaAddr = aa; regbRd = brd; regbAddr = ba;
  endtask
  task automatic read_both(input logic [4:0] aa, input logic [4:0] ba,
                           input logic [31:0] ea, input logic [31:0] eb, input string name);
    drive(1'b0, 5'd0, 32'd0, 1'b1, aa, 1'b1, ba);
    sb.push_back('{ea, eb});
    #1;
    e = sb.pop_front();
    check({name, "_a"}, regaData, e.a);
    check({name, "_b"}, regbData, e.b);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd7,  1'b0, 5'd7,  32'h0,        32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 5'd9,  32'h12345678, 1'b1, 5'd7,  1'b1, 5'd9,  32'hDEADBEEF, 32'h12345678};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd9,  32'h12345678, 32'h12345678};
    tbl[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    tbl[6]  = '{1'b1, 5'd9,  32'hAAAA5555, 1'b1, 5'd9,  1'b1, 5'd9,  32'hAAAA5555, 32'hAAAA5555};
    tbl[7]  = '{1'b1, 5'd7,  32'hCAFEF00D, 1'b0, 5'd7,  1'b1, 5'd7,  32'h0,        32'hCAFEF00D};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd9,  32'hCAFEF00D, 32'hAAAA5555};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd3,  32'h0,        32'h0};
    tbl[10] = '{1'b1, 5'd31, 32'hFFFF0000, 1'b1, 5'd30, 1'b1, 5'd31, 32'h0,        32'hFFFF0000};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd31, 32'hFFFF0000, 32'hFFFF0000};
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    repeat (3) step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    check("rst_rda", regaData, 32'd0);
    rst = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      if (n == 10) begin regcWr = 1'b1; regcAddr = 5'd3; regcData = 32'h55; end
      step();
      regcWr = 1'b0;
      check($sformatf("sweep_ready_%0d", n), {31'd0, ready}, {31'd0, n == 32});
      check($sformatf("sweep_rda_%0d", n), regaData, 32'd0);
      if (n == 9) check("pre_wr_err", {31'd0, wr_err}, 32'd0);
      if (n == 10) check("sweep_wr_err", {31'd0, wr_err}, 32'd1);
    end
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].wr, tbl[i].waddr, tbl[i].wdata, tbl[i].ard, tbl[i].aaddr, tbl[i].brd, tbl[i].baddr);
      sb.push_back('{tbl[i].ea, tbl[i].eb});
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_a", i), regaData, e.a);
      check($sformatf("vec%0d_b", i), regbData, e.b);
      step();
    end
    read_both(5'd3, 5'd0, 32'd0, 32'd0, "r3_dropped");
    check("wr_err_sticky", {31'd0, wr_err}, 32'd1);
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, 5'(r), 32'(r), 1'b0, 5'd0, 1'b0, 5'd0);
      step();
    end
    read_both(5'd1, 5'd4, 32'd1, 32'd4, "fill");
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_wr_err", {31'd0, wr_err}, 32'd0);
    read_both(5'd1, 5'd2, 32'd0, 32'd0, "midrst_gate");
    for (int n = 1; n <= 32; n++) begin
      if (n == 32) drive(1'b1, 5'd1, 32'h77, 1'b0, 5'd0, 1'b0, 5'd0);
      step();
      regcWr = 1'b0;
      check($sformatf("resweep_ready_%0d", n), {31'd0, ready}, {31'd0, n == 32});
      if (n == 31) check("resweep_wr_err_pre", {31'd0, wr_err}, 32'd0);
      if (n == 32) check("last_edge_wr_err", {31'd0, wr_err}, 32'd1);
    end
    read_both(5'd1, 5'd2, 32'd0, 32'd0, "clr12");
    read_both(5'd3, 5'd4, 32'd0, 32'd0, "clr34");
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule
